// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: opcode constants, fetch FSM states and the
// opcode legality helper used by the fetch unit and the control decoder.
package fetch_pkg;

  localparam int INST_W = 32;

  localparam logic [6:0] OP_RTYPE = 7'd51;
  localparam logic [6:0] OP_LD    = 7'd3;
  localparam logic [6:0] OP_SD    = 7'd35;
  localparam logic [6:0] OP_BEQ   = 7'd99;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  function automatic logic op_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LD, OP_SD, OP_BEQ: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, single-outstanding imem handshake and a one-entry
// buffer toward decode. Optional perf counters under macro FETCH_PERF_CNT_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [XLEN-1:0]   imem_addr,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [6:0]        opcode,
  output logic [XLEN-1:0]   inst_pc,
  output logic              inst_illegal,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       fetch_count,
  output logic [31:0]       flush_count,
`endif
  input  logic              redirect,
  input  logic [XLEN-1:0]   redirect_pc
);

  fetch_state_t      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
  logic              accept_s;
  logic              flush_s;
  logic              unused_s;

  // Branch targets are word aligned; the low bits are dropped on purpose.
  assign unused_s = ^redirect_pc[1:0];

  // State, PC and instruction buffer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= {INST_W{1'b0}};
      inst_pc_q <= {XLEN{1'b0}};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  // Next-state, PC update and buffer capture.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    accept_s  = 1'b0;
    flush_s   = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          state_d = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid && redirect) begin
          flush_s = 1'b1;
          state_d = FETCH;
        end else if (imem_rvalid) begin
          inst_d    = imem_rdata;
          inst_pc_d = pc_q;
          pc_d      = pc_q + {{(XLEN-3){1'b0}}, 3'b100};
          state_d   = HOLD;
        end else if (redirect) begin
          state_d = DRAIN;
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (inst_ready) begin
          accept_s = 1'b1;
          state_d  = FETCH;
        end else if (redirect) begin
          flush_s = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = HOLD;
        end
      end
      DRAIN: begin
        // The stale response retires the outstanding request even if another
        // redirect lands in the same cycle; otherwise DRAIN would never exit.
        if (imem_rvalid) begin
          flush_s = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    if (redirect) begin
      pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else begin
      pc_d = pc_d;
    end
  end

  assign imem_req     = (state_q == FETCH);
  assign imem_addr    = pc_q;
  assign inst_valid   = (state_q == HOLD);
  assign inst         = inst_q;
  assign opcode       = inst_q[6:0];
  assign inst_pc      = inst_pc_q;
  assign inst_illegal = inst_valid & ~op_legal(inst_q[6:0]);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  // Handshake and discard counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (accept_s) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if (flush_s) begin
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign flush_count = flush_cnt_q;
`else
  logic unused_perf_s;
  assign unused_perf_s = accept_s ^ flush_s;
`endif

endmodule
